// File: rtl/piezo_pkg.sv
// piezo_pkg: play-state encoding and default timing constants,
// shared by the song select stage and the piezo song player.
package piezo_pkg;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEB_CYCLES      = 20000;
    localparam int DEF_GAP_CYCLES      = 2;
    localparam int DEF_AUTOSTOP_CYCLES = 60000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY_A = 2'd1,
        ST_PLAY_T = 2'd2,
        ST_GAP    = 2'd3
    } state_e;

    typedef enum logic {
        TGT_A = 1'b0,
        TGT_T = 1'b1
    } tgt_e;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piezo_key_debounce.sv
// piezo_key_debounce: synchroniser, level debouncer and one-cycle
// press pulse for a single raw active-high push-button.
module piezo_key_debounce
    import piezo_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_press
);

    localparam int CW = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_stable;
    logic                   r_stable_d;
    logic                   r_press;
    logic                   w_sync;

    assign w_sync  = r_sync[SYNC_STAGES-1];
    assign o_press = r_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
        end
    end

    // Level must differ for DEB_CYCLES consecutive cycles to be accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (w_sync == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt    <= '0;
            r_stable <= ~r_stable;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

endmodule

// File: rtl/piezo_song_select.sv
// piezo_song_select: debounced keys drive a play-state FSM producing the
// exclusive A/T song selects. Optional play timer: PIEZO_AUTOSTOP_EN.
module piezo_song_select
    import piezo_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES      = DEF_DEB_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES
`ifdef PIEZO_AUTOSTOP_EN
    ,
    parameter int AUTOSTOP_CYCLES = DEF_AUTOSTOP_CYCLES
`endif
) (
    input  logic CLK_1MHZ,
    input  logic RESETN,
    input  logic KEY_A,
    input  logic KEY_T,
    input  logic KEY_STOP,
    output logic A,
    output logic T,
    output logic PLAYING
);

    localparam int GW = cnt_w(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

    logic w_p_a;
    logic w_p_t;
    logic w_p_stop;

    state_e r_state;
    state_e w_next;
    tgt_e   r_tgt;
    tgt_e   w_tgt;

    logic [GW-1:0] r_gap_cnt;
    logic          r_a;
    logic          r_t;
    logic          r_playing;
    logic          w_in_play;
    logic          w_timeout;

    assign A       = r_a;
    assign T       = r_t;
    assign PLAYING = r_playing;

    piezo_key_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_a (
        .i_clk  (CLK_1MHZ),
        .i_rst_n(RESETN),
        .i_key  (KEY_A),
        .o_press(w_p_a)
    );

    piezo_key_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_t (
        .i_clk  (CLK_1MHZ),
        .i_rst_n(RESETN),
        .i_key  (KEY_T),
        .o_press(w_p_t)
    );

    piezo_key_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_stop (
        .i_clk  (CLK_1MHZ),
        .i_rst_n(RESETN),
        .i_key  (KEY_STOP),
        .o_press(w_p_stop)
    );

    assign w_in_play = (r_state == ST_PLAY_A) || (r_state == ST_PLAY_T);

`ifdef PIEZO_AUTOSTOP_EN
    localparam int TW = cnt_w(AUTOSTOP_CYCLES);
    localparam logic [TW-1:0] TMR_MAX = TW'(AUTOSTOP_CYCLES - 1);

    logic [TW-1:0] r_tmr;

    assign w_timeout = w_in_play && (r_tmr == TMR_MAX);

    // Restarts on every entry into a play state, including via GAP.
    always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
        if (!RESETN) begin
            r_tmr <= '0;
        end else if (w_in_play && (w_next == r_state)) begin
            r_tmr <= r_tmr + 1'b1;
        end else begin
            r_tmr <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_tgt  = r_tgt;
        if (w_p_stop || w_timeout) begin
            w_next = ST_IDLE;
        end else if (r_state == ST_GAP) begin
            if (r_gap_cnt == GAP_MAX) begin
                w_next = (r_tgt == TGT_T) ? ST_PLAY_T : ST_PLAY_A;
            end
        end else if (!(w_p_a && w_p_t)) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_p_a) begin
                        w_next = ST_PLAY_A;
                    end else if (w_p_t) begin
                        w_next = ST_PLAY_T;
                    end
                end
                ST_PLAY_A: begin
                    if (w_p_a) begin
                        w_next = ST_IDLE;
                    end else if (w_p_t) begin
                        w_next = ST_GAP;
                        w_tgt  = TGT_T;
                    end
                end
                ST_PLAY_T: begin
                    if (w_p_t) begin
                        w_next = ST_IDLE;
                    end else if (w_p_a) begin
                        w_next = ST_GAP;
                        w_tgt  = TGT_A;
                    end
                end
                default: begin
                    w_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
        if (!RESETN) begin
            r_state   <= ST_IDLE;
            r_tgt     <= TGT_A;
            r_gap_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_tgt     <= w_tgt;
            r_gap_cnt <= ((r_state == ST_GAP) && (w_next == ST_GAP))
                       ? r_gap_cnt + 1'b1 : '0;
        end
    end

    // Selects follow next-state so both are low for the whole gap.
    always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
        if (!RESETN) begin
            r_a       <= 1'b0;
            r_t       <= 1'b0;
            r_playing <= 1'b0;
        end else begin
            r_a       <= (w_next == ST_PLAY_A);
            r_t       <= (w_next == ST_PLAY_T);
            r_playing <= (w_next == ST_PLAY_A) || (w_next == ST_PLAY_T);
        end
    end

endmodule
